// File: rtl/auth_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | auth_controller_if : setter/guesser handshake bundle for auth ctrl |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface auth_controller_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 3
);
  localparam int FCW = $clog2(MAX_TRIES + 1);

  logic             set_valid;
  logic [WIDTH-1:0] set_code;
  logic             guess_valid;
  logic [WIDTH-1:0] guess_code;
  logic             guess_ready;
  logic             armed;
  logic             grant;
  logic             deny;
  logic             locked;
  logic [FCW-1:0]   fail_count;

  modport master (
    output set_valid, set_code, guess_valid, guess_code,
    input  guess_ready, armed, grant, deny, locked, fail_count
  );

  modport slave (
    input  set_valid, set_code, guess_valid, guess_code,
    output guess_ready, armed, grant, deny, locked, fail_count
  );
endinterface
`default_nettype wire

// File: rtl/auth_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | auth_controller : stores a code, checks guesses, locks out on abuse |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module auth_controller #(
  parameter int WIDTH       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  auth_controller_if.slave    bus
);

  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] C_MAX_FAIL  = CW'(MAX_TRIES);
  localparam logic [LW-1:0] C_LOCK_LOAD = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    UNSET  = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_code;
  logic [CW-1:0]    r_fail_count;
  logic [LW-1:0]    r_lock_cnt;
  logic             r_grant;
  logic             r_deny;
  logic             r_armed;
  logic             r_locked;

  logic             w_guess_ready;
  logic [CW-1:0]    w_fail_next;

  // A set in the same cycle wins over a guess, so readiness drops combinationally.
  assign w_guess_ready = (r_state == ARMED) && !bus.set_valid;
  assign w_fail_next   = r_fail_count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= UNSET;
      r_code       <= '0;
      r_fail_count <= '0;
      r_lock_cnt   <= '0;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
      r_armed      <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_grant <= 1'b0;
      r_deny  <= 1'b0;
      case (r_state)
        UNSET: begin
          if (bus.set_valid) begin
            r_code       <= bus.set_code;
            r_fail_count <= '0;
            r_state      <= ARMED;
            r_armed      <= 1'b1;
          end
        end
        ARMED: begin
          if (bus.set_valid) begin
            r_code       <= bus.set_code;
            r_fail_count <= '0;
          end else if (bus.guess_valid) begin
            if (bus.guess_code == r_code) begin
              r_grant      <= 1'b1;
              r_fail_count <= '0;
            end else begin
              r_deny <= 1'b1;
              if (w_fail_next == C_MAX_FAIL) begin
                r_fail_count <= C_MAX_FAIL;
                r_state      <= LOCKED;
                r_locked     <= 1'b1;
                r_lock_cnt   <= C_LOCK_LOAD;
              end else begin
                r_fail_count <= w_fail_next;
              end
            end
          end
        end
        LOCKED: begin
          // Counter loaded with LOCK_CYCLES-1 gives exactly LOCK_CYCLES locked cycles.
          if (r_lock_cnt == '0) begin
            r_state      <= ARMED;
            r_locked     <= 1'b0;
            r_fail_count <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= UNSET;
          r_armed  <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.guess_ready = w_guess_ready;
  assign bus.armed       = r_armed;
  assign bus.grant       = r_grant;
  assign bus.deny        = r_deny;
  assign bus.locked      = r_locked;
  assign bus.fail_count  = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_auth_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_auth_controller : directed scoreboard bench for auth_controller  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_auth_controller;

  localparam int WIDTH       = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;

  typedef struct {
    logic       grant;
    logic       deny;
    logic [7:0] fail;
    logic       locked;
  } result_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  result_t sb[$];
  logic [WIDTH-1:0] m_code;
  int   m_fail;

  auth_controller_if #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) bus ();

  auth_controller #(
    .WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " grant"}, {7'd0, bus.grant}, 8'd0);
    check({tag, " deny"},  {7'd0, bus.deny},  8'd0);
  endtask

  task automatic do_set(input logic [WIDTH-1:0] code);
    bus.set_valid = 1'b1;
    bus.set_code  = code;
    step();
    bus.set_valid = 1'b0;
    m_code = code;
    m_fail = 0;
    #1;
    check("set armed", {7'd0, bus.armed}, 8'd1);
    check("set ready", {7'd0, bus.guess_ready}, 8'd1);
    check("set fail_count", 8'(bus.fail_count), 8'd0);
  endtask

  // Drives one guess for a cycle; expected results are queued when accepted.
  task automatic do_guess(input logic [WIDTH-1:0] code, input logic exp_ready, input string tag);
    result_t r;
    bus.guess_valid = 1'b1;
    bus.guess_code  = code;
    #1;
    check({tag, " ready"}, {7'd0, bus.guess_ready}, {7'd0, exp_ready});
    if (exp_ready) begin
      if (code == m_code) begin
        m_fail = 0;
        sb.push_back('{1'b1, 1'b0, 8'd0, 1'b0});
      end else begin
        m_fail++;
        sb.push_back('{1'b0, 1'b1, 8'(m_fail), (m_fail == MAX_TRIES)});
      end
    end
    step();
    bus.guess_valid = 1'b0;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check({tag, " grant"},  {7'd0, bus.grant},  {7'd0, r.grant});
      check({tag, " deny"},   {7'd0, bus.deny},   {7'd0, r.deny});
      check({tag, " fail"},   8'(bus.fail_count), r.fail);
      check({tag, " locked"}, {7'd0, bus.locked}, {7'd0, r.locked});
    end else begin
      check_quiet(tag);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_code   = '0;
    m_fail   = 0;
    rst_n    = 1'b0;
    bus.set_valid   = 1'b0;
    bus.set_code    = '0;
    bus.guess_valid = 1'b0;
    bus.guess_code  = '0;
    #12;
    check("rst armed",  {7'd0, bus.armed},  8'd0);
    check("rst locked", {7'd0, bus.locked}, 8'd0);
    check("rst ready",  {7'd0, bus.guess_ready}, 8'd0);
    check("rst fail",   8'(bus.fail_count), 8'd0);
    check_quiet("rst");
    rst_n = 1'b1;
    step();

    // Guesses are ignored until a code is stored.
    do_guess(4'h5, 1'b0, "unset");
    check("unset armed", {7'd0, bus.armed}, 8'd0);

    do_set(4'hA);
    do_guess(4'hA, 1'b1, "grantA");
    step();
    check_quiet("grantA after");

    do_set(4'h3);
    do_guess(4'h0, 1'b1, "deny0");
    do_guess(4'h1, 1'b1, "deny1");
    do_guess(4'h3, 1'b1, "grant3");

    // Lockout: third failure locks for LOCK_CYCLES cycles; set and guesses ignored.
    do_set(4'hF);
    do_guess(4'h1, 1'b1, "lockA");
    do_guess(4'h2, 1'b1, "lockB");
    do_guess(4'h3, 1'b1, "lockC");
    bus.guess_valid = 1'b1;
    bus.guess_code  = 4'hF;
    for (int k = 2; k <= LOCK_CYCLES; k++) begin
      bus.set_valid = (k == 4);
      bus.set_code  = 4'h2;
      step();
      check("lock held",  {7'd0, bus.locked},      8'd1);
      check("lock ready", {7'd0, bus.guess_ready}, 8'd0);
      check_quiet("lock");
    end
    bus.set_valid = 1'b0;
    step();
    m_fail = 0;
    check("unlock locked", {7'd0, bus.locked},      8'd0);
    check("unlock ready",  {7'd0, bus.guess_ready}, 8'd1);
    check("unlock fail",   8'(bus.fail_count),      8'd0);
    check_quiet("unlock");
    do_guess(4'hF, 1'b1, "post-lock grantF");

    // Set wins over a coincident guess.
    bus.set_valid   = 1'b1;
    bus.set_code    = 4'h7;
    bus.guess_valid = 1'b1;
    bus.guess_code  = 4'h7;
    #1;
    check("coincide ready", {7'd0, bus.guess_ready}, 8'd0);
    step();
    bus.set_valid   = 1'b0;
    bus.guess_valid = 1'b0;
    m_code = 4'h7;
    m_fail = 0;
    check_quiet("coincide");
    do_guess(4'h7, 1'b1, "grant7");

    // Reset in the middle of a lockout clears everything immediately.
    do_guess(4'h0, 1'b1, "rlockA");
    do_guess(4'h1, 1'b1, "rlockB");
    do_guess(4'h2, 1'b1, "rlockC");
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-lock rst locked", {7'd0, bus.locked}, 8'd0);
    check("mid-lock rst armed",  {7'd0, bus.armed},  8'd0);
    check("mid-lock rst fail",   8'(bus.fail_count), 8'd0);
    step();
    rst_n = 1'b1;
    m_fail = 0;
    do_guess(4'h7, 1'b0, "post-rst");
    step();
    check("post-rst armed", {7'd0, bus.armed}, 8'd0);
    check("post-rst ready", {7'd0, bus.guess_ready}, 8'd0);
    do_set(4'h9);
    do_guess(4'h9, 1'b1, "final grant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
